// File: rtl/rx_byte_fifo_if.sv
//==============================================================================
// Module      : rx_byte_fifo_if
// Description : Bus bundle between the UART receive path, the receive byte
//               FIFO and its consumer (the 7-segment display path).
//               master : drives write/pop/clear requests, observes status.
//               slave  : the FIFO itself.
//   wr_en / wr_data     : received byte strobe and data
//   rd_en               : single-cycle pop request
//   clr_flags           : clears sticky overflow/underflow
//   rd_data / rd_valid  : last popped byte and its one-cycle update strobe
//   empty / full / count: occupancy status
//   overflow/underflow  : sticky error flags
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rx_byte_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              clr_flags;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_flags,
        input  rd_data, rd_valid, empty, full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_flags,
        output rd_data, rd_valid, empty, full, count, overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/rx_byte_fifo.sv
//==============================================================================
// Module      : rx_byte_fifo
// Description : Receive-side byte FIFO between the UART receiver and the
//               display path. Holds up to DEPTH bytes in arrival order,
//               releases one byte per pop request with one cycle of latency,
//               tracks occupancy and flags dropped writes / refused pops.
// Ports       :
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high reset
//   bus    - rx_byte_fifo_if.slave (write/pop/clear in, data/status out)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rx_byte_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  wire logic     clk,
    input  wire logic     reset,
    rx_byte_fifo_if.slave bus
);

    localparam logic [ADDR_W:0]   c_full_count = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_count_one  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);

    // Storage (not reset)
    logic [DATA_W-1:0] mem_q [DEPTH];

    // State registers
    logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic [ADDR_W:0]   count_q,     count_d;
    logic              empty_q,     empty_d;
    logic              full_q,      full_d;
    logic [DATA_W-1:0] rd_data_q,   rd_data_d;
    logic              rd_valid_q,  rd_valid_d;
    logic              overflow_q,  overflow_d;
    logic              underflow_q, underflow_d;

    logic w_wr_accept;
    logic w_rd_accept;
    logic w_ovf_event;
    logic w_udf_event;

    // A pop frees a slot in the same edge, so a write into a full FIFO is
    // accepted when a pop accompanies it. Full implies non-empty, so that
    // pop is always accepted too.
    assign w_wr_accept = bus.wr_en & (~full_q | bus.rd_en);
    assign w_rd_accept = bus.rd_en & ~empty_q;
    assign w_ovf_event = bus.wr_en & ~w_wr_accept;
    assign w_udf_event = bus.rd_en & empty_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;

        if (w_wr_accept) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end

        // Memory read uses the pre-edge contents, so a full-FIFO
        // simultaneous write/pop returns the oldest byte, not the new one.
        if (w_rd_accept) begin
            rd_ptr_d   = rd_ptr_q + c_ptr_one;
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
        end

        unique case ({w_wr_accept, w_rd_accept})
            2'b10:   count_d = count_q + c_count_one;
            2'b01:   count_d = count_q - c_count_one;
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == c_full_count);

        // A new event in the clearing cycle wins over the clear.
        overflow_d  = w_ovf_event | (overflow_q  & ~bus.clr_flags);
        underflow_d = w_udf_event | (underflow_q & ~bus.clr_flags);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Writes are blocked during reset so reset keeps priority over wr_en.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_accept) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_byte_fifo.sv
//==============================================================================
// Module      : tb_rx_byte_fifo
// Description : Self-checking testbench for rx_byte_fifo. Bytes accepted by
//               the FIFO are pushed to a scoreboard queue and popped when the
//               DUT presents them on rd_data.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rx_byte_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    rx_byte_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rx_byte_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [7:0] sb [$];
    int         m_count;
    logic [7:0] m_last;

    int n_checks = 0;
    int n_err    = 0;

    // One clock of stimulus: inputs set on the falling edge, DUT samples on
    // the rising edge, outputs are observed 1 time unit later.
    task automatic drive(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
        bit wacc;
        bit racc;
        @(negedge clk);
        bus.wr_en     = wr;
        bus.wr_data   = d;
        bus.rd_en     = rd;
        bus.clr_flags = clr;
        wacc = wr && ((m_count < DEPTH) || rd);
        racc = rd && (m_count > 0);
        if (wacc) sb.push_back(d);
        if (wacc && !racc) m_count++;
        else if (racc && !wacc) m_count--;
        @(posedge clk);
        #1;
        bus.wr_en     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.rd_en     = 1'b0;
        bus.clr_flags = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_count = 0;
        m_last  = 8'h00;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        n_checks++; if (bus.rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h expected 00", bus.rd_data); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b expected 0", bus.rd_valid); end
        n_checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: got ovf=%b udf=%b expected 0 0", bus.overflow, bus.underflow);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
            repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0);
        end
        n_checks++; if (bus.count !== 4'd3) begin n_err++; $display("FAIL basic_count: got %0d expected 3", bus.count); end
        n_checks++; if (bus.empty !== 1'b0) begin n_err++; $display("FAIL basic_empty: got %b expected 0", bus.empty); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL basic_rd_valid: got %b expected 1", bus.rd_valid); end
            exp = sb.pop_front();
            m_last = exp;
            n_checks++; if (bus.rd_data !== exp) begin n_err++; $display("FAIL basic_rd_data: got %h expected %h", bus.rd_data, exp); end
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            n_checks++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_rd_valid_pulse: got %b expected 0", bus.rd_valid); end
        end
        n_checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
            n_err++; $display("FAIL basic_drained: got count=%0d empty=%b expected 0 1", bus.count, bus.empty);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        n_checks++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin
            n_err++; $display("FAIL ovf_fill: got full=%b count=%0d expected 1 8", bus.full, bus.count);
        end
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        n_checks++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
        n_checks++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d expected 8", bus.count); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            exp = sb.pop_front();
            m_last = exp;
            n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
                n_err++; $display("FAIL ovf_pop: got valid=%b data=%h expected 1 %h", bus.rd_valid, bus.rd_data, exp);
            end
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
    endtask

    task automatic test_underflow();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL udf_flag: got %b expected 1", bus.underflow); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL udf_rd_valid: got %b expected 0", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== m_last) begin n_err++; $display("FAIL udf_rd_data: got %h expected %h", bus.rd_data, m_last); end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL udf_set_wins: got %b expected 1", bus.underflow); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL udf_clear: got %b expected 0", bus.underflow); end
    endtask

    task automatic test_full_simul();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        exp = sb.pop_front();
        m_last = exp;
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h10 || exp !== 8'h10) begin
            n_err++; $display("FAIL full_simul_data: got valid=%b data=%h expected 1 10", bus.rd_valid, bus.rd_data);
        end
        n_checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin
            n_err++; $display("FAIL full_simul_count: got count=%0d full=%b expected 8 1", bus.count, bus.full);
        end
        n_checks++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL full_simul_ovf: got %b expected 0", bus.overflow); end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            exp = sb.pop_front();
            m_last = exp;
            n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
                n_err++; $display("FAIL full_simul_pop: got valid=%b data=%h expected 1 %h", bus.rd_valid, bus.rd_data, exp);
            end
        end
        n_checks++; if (bus.rd_data !== 8'hAA) begin n_err++; $display("FAIL full_simul_last: got %h expected aa", bus.rd_data); end
    endtask

    task automatic test_empty_simul();
        logic [7:0] exp;
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        n_checks++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL empty_simul_count: got %0d expected 1", bus.count); end
        n_checks++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL empty_simul_udf: got %b expected 1", bus.underflow); end
        n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== m_last) begin
            n_err++; $display("FAIL empty_simul_nobypass: got valid=%b data=%h expected 0 %h", bus.rd_valid, bus.rd_data, m_last);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        exp = sb.pop_front();
        m_last = exp;
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h55 || exp !== 8'h55) begin
            n_err++; $display("FAIL empty_simul_pop: got valid=%b data=%h expected 1 55", bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            exp = sb.pop_front();
            n_checks++; if (bus.rd_data !== exp) begin n_err++; $display("FAIL mid_pop: got %h expected %h", bus.rd_data, exp); end
        end
        apply_reset();
        n_checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin
            n_err++; $display("FAIL mid_reset: got count=%0d empty=%b data=%h expected 0 1 00", bus.count, bus.empty, bus.rd_data);
        end
        drive(1'b1, 8'h99, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        exp = sb.pop_front();
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h99 || exp !== 8'h99) begin
            n_err++; $display("FAIL mid_after_reset: got valid=%b data=%h expected 1 99", bus.rd_valid, bus.rd_data);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            exp = sb.pop_front();
            n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
                n_err++; $display("FAIL wrap_pair: got valid=%b data=%h expected 1 %h", bus.rd_valid, bus.rd_data, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
            exp = sb.pop_front();
            n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp || bus.count !== 4'(m_count)) begin
                n_err++; $display("FAIL b2b: got valid=%b data=%h count=%0d expected 1 %h %0d",
                                  bus.rd_valid, bus.rd_data, bus.count, exp, m_count);
            end
        end
        n_checks++; if (bus.count !== 4'd4 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_err++; $display("FAIL b2b_end: got count=%0d ovf=%b udf=%b expected 4 0 0", bus.count, bus.overflow, bus.underflow);
        end
    endtask

    initial begin
        bus.wr_en     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.rd_en     = 1'b0;
        bus.clr_flags = 1'b0;
        m_count       = 0;
        m_last        = 8'h00;

        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_full_simul();
        test_empty_simul();
        test_reset_mid();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
